// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state type, frame constants, baud helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   tx_state_t      transmitter FSM states
//   UART_DATA_BITS  data bits per 8N1 frame
//   bit_period()    clocks per UART bit derived from the half-bit count
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // The receive path counts half bits so it can centre its samples; the
  // transmitter only needs whole bit periods.
  function automatic int bit_period(input int clk_per_half_bit);
    return 2 * clk_per_half_bit;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 serialiser: one byte per frame, LSB first.
// Latency: byte accepted in IDLE on edge E; start bit drives txd from edge E.
// Backpressure: ready is high only in IDLE; valid is ignored while a frame runs.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   valid      a byte is offered on data
//   data[7:0]  byte to send, captured when valid && ready
//   ready      transmitter idle and able to take a byte this cycle
//   txd        serial line, idle high
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);
  import uart_pkg::*;

  localparam int BIT_CLKS = bit_period(CLK_PER_HALF_BIT);
  localparam int BAUD_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  tx_state_t                 state_nxt;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [BAUD_W-1:0]         baud_nxt;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          idx_nxt;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_nxt;
  logic                      period_end;

  assign period_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      shift    <= shift_nxt;
    end
  end

  // txd is decoded from registered state only, so an asynchronous reset
  // returns the line high at once and abandons any partial frame.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    ready     = 1'b0;
    txd       = 1'b1;

    // Every non-idle state lasts exactly one bit period.
    if (state != IDLE) begin
      baud_nxt = period_end ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        ready    = 1'b1;
        baud_nxt = '0;
        if (valid) begin
          shift_nxt = data;
          state_nxt = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (period_end) begin
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        txd = shift[0];
        if (period_end) begin
          shift_nxt = {1'b0, shift[UART_DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (period_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/output_unit.sv
// Execute-stage `out` path: queues s[7:0] in a FIFO and sends each byte as UART 8N1.
// Latency: push at edge N, popped at N+1, start bit on txd from N+1 for one bit period.
// Backpressure: out_stall is high while the FIFO is full; a push at that edge is dropped.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   is_out      execute stage issues an `out` this cycle
//   s[31:0]     source operand; only s[7:0] is queued
//   out_stall   FIFO full, pipeline must hold the `out`
//   txd         UART serial output, idle high
//   tx_busy     bytes queued or a frame in progress
//   fifo_count  bytes queued, not counting the one being shifted out
module output_unit #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int FIFO_LOG2        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_out,
  input  logic [31:0]          s,
  output logic                 out_stall,
  output logic                 txd,
  output logic                 tx_busy,
  output logic [FIFO_LOG2:0]   fifo_count
);
  import uart_pkg::*;

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W = FIFO_LOG2 + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 not_empty;
  logic                 push;
  logic                 pop;
  logic                 tx_ready;
  logic                 unused_s_hi;

  // The upper operand bits carry nothing for the serial line.
  assign unused_s_hi = ^s[31:8];

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);

  // Stall comes from registered state only, so a pop this cycle frees the
  // slot for the next cycle rather than combinationally accepting now.
  assign push = is_out && !full;
  assign pop  = tx_ready && not_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s[7:0];
    end
  end

  // Pointers wrap naturally at the FIFO depth; count carries the extra bit
  // that distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  uart_tx #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (not_empty),
    .data  (mem[rd_ptr]),
    .ready (tx_ready),
    .txd   (txd)
  );

  assign out_stall  = full;
  assign fifo_count = count;
  // The transmitter is ready exactly when its FSM is idle.
  assign tx_busy    = not_empty || !tx_ready;

endmodule

// File: tb/tb_output_unit.sv
module tb_output_unit;

  localparam int CPH   = 4;
  localparam int FL2   = 3;
  localparam int DEPTH = 8;
  localparam int BITP  = 2 * CPH;
  localparam int FRAME = 10 * BITP;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         is_out = 1'b0;
  logic [31:0]  s = '0;
  logic         out_stall;
  logic         txd;
  logic         tx_busy;
  logic [FL2:0] fifo_count;

  output_unit #(
    .CLK_PER_HALF_BIT(CPH),
    .FIFO_LOG2(FL2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .is_out     (is_out),
    .s          (s),
    .out_stall  (out_stall),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a queue of waiting bytes plus a frame clock. A frame
  // lasts FRAME cycles from the pop; an idle transmitter with queued bytes
  // pops on the next edge.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur = '0;
  bit         m_active = 0;
  int         m_phase = 0;

  // Line receiver: samples mid-bit and logs decoded bytes.
  bit         rx_on = 0;
  int         rx_t = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_log[$];

  bit         last_stalled = 0;

  typedef struct {
    int         k;
    logic       txd;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic exp_txd();
    if (!m_active) return 1'b1;
    if (m_phase < BITP) return 1'b0;
    if (m_phase < 9 * BITP) return m_cur[(m_phase - BITP) / BITP];
    return 1'b1;
  endfunction

  task automatic rx_sample();
    if (!rx_on) begin
      if (txd == 1'b0) begin
        rx_on = 1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t == BITP / 2) begin
        chk("rx_start", txd, 0);
      end else if (rx_t >= BITP + BITP / 2 && rx_t < 9 * BITP && ((rx_t - BITP / 2) % BITP) == 0) begin
        rx_byte[(rx_t - BITP - BITP / 2) / BITP] = txd;
      end else if (rx_t == 9 * BITP + BITP / 2) begin
        rx_on = 0;
        chk("rx_stop", txd, 1);
        rx_log.push_back(rx_byte);
        chk("rx_expected_frame", m_sent.size() > 0, 1);
        if (m_sent.size() > 0) chk("rx_byte", rx_byte, m_sent.pop_front());
      end
    end
  endtask

  task automatic step(input logic io, input logic [31:0] sv);
    bit pop;
    bit acc;
    is_out = io;
    s = sv;
    last_stalled = io && out_stall;
    @(posedge clk);
    pop = !m_active && (m_q.size() > 0);
    acc = io && (m_q.size() < DEPTH);
    if (m_active) begin
      m_phase++;
      if (m_phase == FRAME) m_active = 0;
    end else if (pop) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_phase  = 0;
      m_active = 1;
    end
    if (acc) m_q.push_back(sv[7:0]);
    #1;
    is_out = 1'b0;
    s = $urandom();
    chk("txd", txd, exp_txd());
    chk("fifo_count", fifo_count, m_q.size());
    chk("out_stall", out_stall, m_q.size() == DEPTH);
    chk("tx_busy", tx_busy, m_active || (m_q.size() > 0));
    rx_sample();
  endtask

  // Called one time unit after an edge; checks the asynchronous effect
  // before the next edge arrives.
  task automatic reset_async();
    rst = 1'b1;
    #1;
    m_q.delete();
    m_sent.delete();
    m_active = 0;
    m_phase  = 0;
    rx_on    = 0;
    chk("rst_txd", txd, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", out_stall, 0);
    chk("rst_busy", tx_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_active || m_q.size() > 0 || rx_on) && n < budget) begin
      step(1'b0, 32'h0);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    chk("all_frames_received", m_sent.size(), 0);
  endtask

  logic [7:0] exp_fill[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
  logic [7:0] exp_pp[4]    = '{8'h11, 8'h22, 8'h33, 8'h77};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vi;
    int stalls[11];
    int att;
    int guard;
    int idx;
    int run_lo1;
    int run_hi;
    int run_lo2;
    logic samp[$];

    // Single-byte frame of 0xA5 at sample k after the push edge.
    tbl[0]  = '{0,  1'b1, 1'b1, 4'd1};
    tbl[1]  = '{1,  1'b0, 1'b1, 4'd0};
    tbl[2]  = '{8,  1'b0, 1'b1, 4'd0};
    tbl[3]  = '{9,  1'b1, 1'b1, 4'd0};
    tbl[4]  = '{16, 1'b1, 1'b1, 4'd0};
    tbl[5]  = '{17, 1'b0, 1'b1, 4'd0};
    tbl[6]  = '{25, 1'b1, 1'b1, 4'd0};
    tbl[7]  = '{33, 1'b0, 1'b1, 4'd0};
    tbl[8]  = '{41, 1'b0, 1'b1, 4'd0};
    tbl[9]  = '{49, 1'b1, 1'b1, 4'd0};
    tbl[10] = '{57, 1'b0, 1'b1, 4'd0};
    tbl[11] = '{65, 1'b1, 1'b1, 4'd0};
    tbl[12] = '{72, 1'b1, 1'b1, 4'd0};
    tbl[13] = '{73, 1'b1, 1'b1, 4'd0};
    tbl[14] = '{80, 1'b1, 1'b1, 4'd0};
    tbl[15] = '{81, 1'b1, 1'b0, 4'd0};

    #1;
    reset_async();

    // Idle after reset
    for (int i = 0; i < 100; i++) step(1'b0, $urandom());

    // Single byte against the table
    vi = 0;
    for (int k = 0; k < 86; k++) begin
      if (k == 0) step(1'b1, 32'hDEAD_BEA5);
      else step(1'b0, $urandom());
      if (vi < 16 && tbl[vi].k == k) begin
        chk($sformatf("tbl_txd_k%0d", k), txd, tbl[vi].txd);
        chk($sformatf("tbl_busy_k%0d", k), tx_busy, tbl[vi].busy);
        chk($sformatf("tbl_count_k%0d", k), fifo_count, tbl[vi].cnt);
        vi++;
      end
    end
    chk("tbl_all_applied", vi, 16);
    drain(200);

    // Fill: the pipeline holds each `out` while stalled
    rx_log.delete();
    for (int v = 1; v <= 10; v++) begin
      att = 0;
      do begin
        step(1'b1, {$urandom_range(0, 32'hFF_FFFF), 8'(v)} );
        att++;
      end while (last_stalled && att < 400);
      stalls[v] = att - 1;
    end
    for (int v = 1; v <= 9; v++) chk($sformatf("fill_push%0d_no_stall", v), stalls[v], 0);
    chk("fill_push10_stalled", stalls[10] > 0, 1);
    drain(1500);
    chk("fill_rx_count", rx_log.size(), 10);
    for (int i = 0; i < 10 && i < rx_log.size(); i++) chk($sformatf("fill_rx%0d", i), rx_log[i], exp_fill[i]);

    // Back-to-back 0x00, 0xFF: stop bit plus one idle clock between frames
    samp.delete();
    step(1'b1, 32'h0000_0000);
    samp.push_back(txd);
    step(1'b1, 32'h0000_00FF);
    samp.push_back(txd);
    for (int i = 0; i < 178; i++) begin
      step(1'b0, $urandom());
      samp.push_back(txd);
    end
    idx = 0;
    run_lo1 = 0;
    run_hi = 0;
    run_lo2 = 0;
    while (idx < samp.size() && samp[idx] == 1'b1) idx++;
    while (idx < samp.size() && samp[idx] == 1'b0) begin run_lo1++; idx++; end
    while (idx < samp.size() && samp[idx] == 1'b1) begin run_hi++; idx++; end
    while (idx < samp.size() && samp[idx] == 1'b0) begin run_lo2++; idx++; end
    chk("b2b_frame1_low_run", run_lo1, 9 * BITP);
    chk("b2b_high_gap", run_hi, BITP + 1);
    chk("b2b_start2_low", run_lo2, BITP);
    drain(300);

    // Reset in DATA bit 3 of 0x55 with 3 bytes queued
    step(1'b1, 32'h0000_0055);
    step(1'b1, 32'h0000_00A1);
    step(1'b1, 32'h0000_00A2);
    step(1'b1, 32'h0000_00A3);
    guard = 0;
    while (!(m_active && m_phase == BITP + 3 * BITP + BITP / 2) && guard < 100) begin
      step(1'b0, $urandom());
      guard++;
    end
    chk("midframe_reached", guard < 100, 1);
    chk("midframe_count", fifo_count, 3);
    reset_async();
    rx_log.delete();
    step(1'b1, 32'h1234_563C);
    drain(300);
    chk("post_rst_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("post_rst_rx_byte", rx_log[0], 8'h3C);

    // Push on the same edge that pops the head with two queued
    rx_log.delete();
    step(1'b1, 32'h0000_0011);
    step(1'b1, 32'h0000_0022);
    step(1'b1, 32'h0000_0033);
    guard = 0;
    while (m_active && guard < 200) begin
      step(1'b0, $urandom());
      guard++;
    end
    chk("pp_idle_reached", guard < 200, 1);
    chk("pp_count_before", fifo_count, 2);
    step(1'b1, 32'h0000_0077);
    chk("pp_count_after", fifo_count, 2);
    drain(600);
    chk("pp_rx_count", rx_log.size(), 4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++) chk($sformatf("pp_rx%0d", i), rx_log[i], exp_pp[i]);

    // Randomized traffic with bursts and one reset
    att = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_async();
      if (i % 500 == 250) att = 12;
      if (att > 0) begin
        step(1'b1, $urandom());
        att--;
      end else begin
        step($urandom_range(0, 39) == 0, $urandom());
      end
    end
    drain(1500);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
